// File: rtl/imm_encode.sv
// Narrows a 32-bit signed value into the 17-bit immediate of an I-type word
// and queues the word in a 2-entry FIFO behind valid/ready handshakes.
module imm_encode #(
  parameter int SAT   = 1,
  parameter int CNT_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_opcode,
  input  logic [4:0]              in_rd,
  input  logic [4:0]              in_rs,
  input  logic signed [31:0]      in_value,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_insn,
  output logic                    out_range_err,
  output logic                    err_sticky,
  output logic [CNT_W-1:0]        err_count
);

  function automatic logic fits17(input logic signed [31:0] v);
    return (v[31:16] == {16{v[16]}});
  endfunction

  function automatic logic [16:0] sat17(input logic signed [31:0] v);
    if (fits17(v) || (SAT == 0)) return v[16:0];
    return v[31] ? 17'h10000 : 17'h0FFFF;
  endfunction

  logic [31:0] mem_insn [2];
  logic        mem_err  [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        push_p0;
  logic        pop_p0;
  logic        err_p0;
  logic [31:0] insn_p0;

  // Stage p0: combinational encode of the presented word
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push_p0   = in_valid && in_ready;
  assign pop_p0    = out_valid && out_ready;
  assign err_p0    = !fits17(in_value);
  assign insn_p0   = {in_opcode, in_rd, in_rs, sat17(in_value)};

  // Stage p1: queue storage; gated by out_valid so stale entries never show
  always_ff @(posedge clock) begin
    if (push_p0) begin
      mem_insn[wr_ptr] <= insn_p0;
      mem_err[wr_ptr]  <= err_p0;
    end
  end

  assign out_insn      = out_valid ? mem_insn[rd_ptr] : 32'd0;
  assign out_range_err = out_valid ? mem_err[rd_ptr]  : 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      if (push_p0) wr_ptr <= ~wr_ptr;
      if (pop_p0)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_p0} - {1'b0, pop_p0};
      if (push_p0 && err_p0) begin
        err_sticky <= 1'b1;
        if (err_count != {CNT_W{1'b1}}) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encode.sv
// Directed bench for imm_encode: a saturating instance and a wrapping,
// narrow-counter instance share stimulus and are checked side by side.
module tb_imm_encode;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_opcode = '0, in_rd = '0, in_rs = '0;
  logic signed [31:0] in_value = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_err, a_sticky;
  logic [31:0] a_out_insn;
  logic [7:0]  a_cnt;
  logic        b_in_ready, b_out_valid, b_out_err, b_sticky;
  logic [31:0] b_out_insn;
  logic [1:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  imm_encode #(.SAT(1), .CNT_W(8)) u_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_value(in_value),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_insn(a_out_insn),
    .out_range_err(a_out_err), .err_sticky(a_sticky), .err_count(a_cnt)
  );

  imm_encode #(.SAT(0), .CNT_W(2)) u_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_value(in_value),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_insn(b_out_insn),
    .out_range_err(b_out_err), .err_sticky(b_sticky), .err_count(b_cnt)
  );

  typedef struct {
    logic [4:0]  op, rd, rs;
    logic [31:0] val;
    logic [16:0] ia, ib;
    logic        er;
    logic [7:0]  ca;
    logic [1:0]  cb;
  } vec_t;

  vec_t v [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [31:0] val);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs = rs; in_value = val;
  endtask

  initial begin
    v[0] = '{5'd5,  5'd3,  5'd7,  32'hFFFF_FFFB, 17'h1FFFB, 17'h1FFFB, 1'b0, 8'd0, 2'd0};
    v[1] = '{5'd1,  5'd1,  5'd2,  32'h0000_FFFF, 17'h0FFFF, 17'h0FFFF, 1'b0, 8'd0, 2'd0};
    v[2] = '{5'd2,  5'd4,  5'd6,  32'hFFFF_0000, 17'h10000, 17'h10000, 1'b0, 8'd0, 2'd0};
    v[3] = '{5'd3,  5'd31, 5'd0,  32'h0001_0000, 17'h0FFFF, 17'h10000, 1'b1, 8'd1, 2'd1};
    v[4] = '{5'd31, 5'd0,  5'd31, 32'h8000_0000, 17'h10000, 17'h00000, 1'b1, 8'd2, 2'd2};
    v[5] = '{5'd7,  5'd8,  5'd9,  32'h0001_2345, 17'h0FFFF, 17'h12345, 1'b1, 8'd3, 2'd3};
    v[6] = '{5'd0,  5'd0,  5'd0,  32'h0000_0000, 17'h00000, 17'h00000, 1'b0, 8'd3, 2'd3};
    v[7] = '{5'd10, 5'd21, 5'd11, 32'hFFFE_FFFF, 17'h10000, 17'h0FFFF, 1'b1, 8'd4, 2'd3};
    v[8] = '{5'd16, 5'd1,  5'd1,  32'h0000_0001, 17'h00001, 17'h00001, 1'b0, 8'd4, 2'd3};
    v[9] = '{5'd4,  5'd5,  5'd6,  32'h7FFF_FFFF, 17'h0FFFF, 17'h1FFFF, 1'b1, 8'd5, 2'd3};

    // Reset state, observed while reset is held low
    #3;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_in_ready",  a_in_ready,  1);
    check("rst_out_insn",  a_out_insn,  0);
    check("rst_range_err", a_out_err,   0);
    check("rst_sticky",    a_sticky,    0);
    check("rst_count",     a_cnt,       0);
    @(negedge clock);
    reset = 1'b1;

    // Table: one word per cycle, consumer always ready
    out_ready = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      drive(v[i].op, v[i].rd, v[i].rs, v[i].val);
      @(posedge clock);
      @(negedge clock);
      check($sformatf("v%0d_a_valid", i), a_out_valid, 1);
      check($sformatf("v%0d_a_ready", i), a_in_ready, 1);
      check($sformatf("v%0d_a_insn", i), a_out_insn, {v[i].op, v[i].rd, v[i].rs, v[i].ia});
      check($sformatf("v%0d_b_insn", i), b_out_insn, {v[i].op, v[i].rd, v[i].rs, v[i].ib});
      check($sformatf("v%0d_a_err", i), a_out_err, v[i].er);
      check($sformatf("v%0d_b_err", i), b_out_err, v[i].er);
      check($sformatf("v%0d_a_cnt", i), a_cnt, v[i].ca);
      check($sformatf("v%0d_b_cnt", i), b_cnt, v[i].cb);
      check($sformatf("v%0d_a_sticky", i), a_sticky, (v[i].ca != 0));
      if (!v[i].er)
        check($sformatf("v%0d_roundtrip", i), {{15{a_out_insn[16]}}, a_out_insn[16:0]}, v[i].val);
      if (i == 0) check("v0_literal", a_out_insn, 32'h28CF_FFFB);
    end
    in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("drain_out_valid", a_out_valid, 0);
    @(posedge clock);
    @(negedge clock);
    check("empty_pop_valid", a_out_valid, 0);
    check("empty_pop_ready", a_in_ready, 1);

    // Backpressure: A, B fill the queue, C waits until a slot frees
    out_ready = 1'b0;
    drive(5'd1, 5'd2, 5'd3, 32'd5);
    @(posedge clock); @(negedge clock);
    check("bp_a_head", a_out_insn, {5'd1, 5'd2, 5'd3, 17'd5});
    check("bp_ready_after_a", a_in_ready, 1);
    drive(5'd4, 5'd5, 5'd6, 32'hFFFF_FFFF);
    @(posedge clock); @(negedge clock);
    check("bp_ready_after_b", a_in_ready, 0);
    drive(5'd7, 5'd8, 5'd9, 32'd2);
    @(posedge clock); @(negedge clock);
    check("bp_full_ready", a_in_ready, 0);
    check("bp_hold_head", a_out_insn, {5'd1, 5'd2, 5'd3, 17'd5});
    out_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    check("bp_b_head", a_out_insn, {5'd4, 5'd5, 5'd6, 17'h1FFFF});
    check("bp_ready_after_pop", a_in_ready, 1);
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0;
    check("bp_c_head", a_out_insn, {5'd7, 5'd8, 5'd9, 17'd2});
    check("bp_pushpop_ready", a_in_ready, 1);
    check("bp_pushpop_valid", a_out_valid, 1);
    @(posedge clock); @(negedge clock);
    check("bp_empty", a_out_valid, 0);

    // Asynchronous reset with two words queued
    out_ready = 1'b0;
    drive(5'd2, 5'd2, 5'd2, 32'h0002_0000);
    @(posedge clock); @(negedge clock);
    drive(5'd3, 5'd3, 5'd3, 32'd9);
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0;
    check("pre_rst_full", a_in_ready, 0);
    check("pre_rst_sticky", a_sticky, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", a_out_valid, 0);
    check("arst_in_ready", a_in_ready, 1);
    check("arst_count", a_cnt, 0);
    check("arst_b_count", b_cnt, 0);
    check("arst_sticky", a_sticky, 0);
    check("arst_insn", a_out_insn, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_valid", a_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
